// File: rtl/risc_pkg.sv
// risc_pkg
// Shared constants for the decode stage: datapath width, register index
// width, the opcodes the decoder treats specially, and the bit positions
// of each instruction field.
//
// Instruction word layout:
//   [31:26] opcode   [25:21] rd   [20:16] rs1   [15:11] rs2   [15:0] imm
// rs2 and imm share bits [15:11]; which one is meaningful depends on opcode.
package risc_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int OPC_W = 6;
    localparam int IMM_W = 16;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_LOAD  = 6'h23;
    localparam logic [OPC_W-1:0] OP_STORE = 6'h2B;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Only register-register and store instructions read rs2; every other
    // opcode reuses those bits as part of the immediate.
    function automatic logic uses_rs2(input logic [OPC_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/decode_stage_hazard_detect.sv
// hazard_detect
// Purely combinational load-use hazard check. A load sitting in the ID/EX
// register cannot forward its result in time for the instruction now in
// decode, so decode must insert one bubble when that instruction reads the
// load's destination.
//
// Ports:
//   ex_valid    in   ID/EX register holds a live instruction
//   ex_is_load  in   that instruction is a load
//   ex_rd       in   its destination register
//   rs1, rs2    in   source registers of the instruction in decode
//   use_rs2     in   decode instruction actually reads rs2
//   hazard      out  stall decode for one cycle
module hazard_detect
    import risc_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             use_rs2,
    output logic             hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = (ex_rd == rs1);
    assign rs2_match = use_rs2 && (ex_rd == rs2);

    // r0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign hazard = ex_valid && ex_is_load && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// Instruction decode with register-file read, writeback bypass, load-use
// stall and the ID/EX pipeline register.
//
// Ports:
//   clk, res                  clock, synchronous active-high reset
//   in_valid/in_instr/in_ready  upstream handshake from IF/ID
//   rf_ra, rf_rb              register-file read addresses (rs1, rs2)
//   rf_da, rf_db              register-file read data
//   wb_en, wb_reg, wb_data    writeback port, bypassed into operands
//   flush                     kill everything in decode
//   ex_valid/ex_ready         downstream handshake to execute
//   ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_is_load   ID/EX register contents
module decode_stage
    import risc_pkg::*;
#(
    parameter int XLEN = risc_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic             clk,
    input  logic             res,

    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_instr,
    output logic             in_ready,

    output logic [REG_W-1:0] rf_ra,
    output logic [REG_W-1:0] rf_rb,
    input  logic [XLEN-1:0]  rf_da,
    input  logic [XLEN-1:0]  rf_db,

    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_reg,
    input  logic [XLEN-1:0]  wb_data,

    input  logic             flush,

    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [OPC_W-1:0] ex_op,
    output logic [REG_W-1:0] ex_rd,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [XLEN-1:0]  ex_imm,
    output logic             ex_is_load
);

    // The register index is fixed at 5 bits and the field layout assumes a
    // word of at least 32 bits.
    if (NREG < 2 || NREG > (1 << REG_W)) begin : g_bad_nreg
        $error("decode_stage: NREG out of range for a 5-bit register index");
    end
    if (XLEN < 32) begin : g_bad_xlen
        $error("decode_stage: XLEN must be at least 32");
    end

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
    logic             use_rs2;
    logic             hazard;
    logic             adv;
    logic [XLEN-1:0]  opnd_a;
    logic [XLEN-1:0]  opnd_b;
    logic [XLEN-1:0]  imm_ext;

    assign opcode  = in_instr[OPC_HI:OPC_LO];
    assign rd      = in_instr[RD_HI:RD_LO];
    assign rs1     = in_instr[RS1_HI:RS1_LO];
    assign rs2     = in_instr[RS2_HI:RS2_LO];
    assign imm     = in_instr[IMM_HI:IMM_LO];
    assign use_rs2 = uses_rs2(opcode);

    assign rf_ra = rs1;
    assign rf_rb = rs2;

    // r0 reads as zero regardless of what the register file returns; a
    // same-cycle writeback to the source register wins over the stale read.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [REG_W-1:0] src,
        input logic [XLEN-1:0]  rf_data,
        input logic             byp_en,
        input logic [REG_W-1:0] byp_reg,
        input logic [XLEN-1:0]  byp_data
    );
        if (src == '0)
            return '0;
        else if (byp_en && (byp_reg == src))
            return byp_data;
        else
            return rf_data;
    endfunction

    assign opnd_a  = pick_operand(rs1, rf_da, wb_en, wb_reg, wb_data);
    // ex_b is always the rs2 read; for non-rs2 opcodes execute simply
    // ignores it, so no extra mux is needed here.
    assign opnd_b  = pick_operand(rs2, rf_db, wb_en, wb_reg, wb_data);
    assign imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

    hazard_detect u_hazard_detect (
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .use_rs2    (use_rs2),
        .hazard     (hazard)
    );

    assign adv = !ex_valid || ex_ready;

    // During flush upstream is told to hand over its word so it can be
    // dropped; the ID/EX register ignores it below.
    always_comb begin
        in_ready = 1'b0;
        if (res)
            in_ready = 1'b0;
        else if (flush)
            in_ready = 1'b1;
        else
            in_ready = adv && !hazard;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            ex_valid   <= 1'b0;
            ex_op      <= '0;
            ex_rd      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_imm     <= '0;
            ex_is_load <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (adv) begin
            if (in_valid && !hazard) begin
                ex_valid   <= 1'b1;
                ex_op      <= opcode;
                ex_rd      <= rd;
                ex_a       <= opnd_a;
                ex_b       <= opnd_b;
                ex_imm     <= imm_ext;
                ex_is_load <= (opcode == OP_LOAD);
            end else begin
                // Bubble: payload fields are don't-care once ex_valid drops,
                // so they are left alone.
                ex_valid <= 1'b0;
            end
        end
    end

endmodule
